// File: rtl/i2c_slave_regfile_if.sv
// Board-level I2C pad signals seen by the register-file slave.
// sda_i is the resolved open-drain line; sda_oe=1 pulls it low.
interface i2c_slave_regfile_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport slave  (input scl_i, input sda_i, output sda_oe);
    modport master (output scl_i, output sda_i, input sda_oe);
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_RW writable and NUM_RO read-only byte registers
// through an auto-incrementing pointer; FSM state is visible on state_o.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         NUM_RW     = 4,
    parameter int         NUM_RO     = 4,
    parameter logic [7:0] RW_RESET   = 8'h00,
    parameter int         FILTER_LEN = 3,
    localparam int NUM_TOT = NUM_RW + NUM_RO,
    localparam int PTR_W   = (NUM_TOT > 1) ? $clog2(NUM_TOT) : 1,
    localparam int RO_W    = 8 * ((NUM_RO > 0) ? NUM_RO : 1)
) (
    input  logic                clk,
    input  logic                rst,
    i2c_slave_regfile_if.slave  bus,
    output logic [8*NUM_RW-1:0] rw_regs_o,
    input  logic [RO_W-1:0]     ro_regs_i,
    output logic                wr_stb_o,
    output logic [PTR_W-1:0]    wr_idx_o,
    output logic                busy_o,
    output logic [3:0]          state_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
    } state_t;

    localparam logic [8:0]       TOT_LIM = 9'(NUM_TOT);
    localparam logic [PTR_W:0]   RW_LIM  = (PTR_W+1)'(NUM_RW);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_TOT - 1);

    state_t           state_q, state_d;
    logic [1:0]       sync1_q, sync2_q, filt_q, filt_d1_q;
    logic [3:0]       flt_cnt_q [2];
    logic [6:0]       shift_q;
    logic [7:0]       tx_q;
    logic [7:0]       rw_q [NUM_RW];
    logic [7:0]       all_regs [NUM_TOT];
    logic [7:0]       rx_byte, rd_byte;
    logic [PTR_W-1:0] ptr_q, ptr_nxt, wr_idx_q;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             sda_oe_q, sda_oe_d, ack_ph_q, ack_ph_d, rd_mode_q, rd_mode_d;
    logic             busy_q, wr_stb_q;
    logic             scl_rise, scl_fall, start_det, stop_det, ptr_is_rw;
    logic             ld_tx, tx_shift, ptr_ld, ptr_inc, wr_en;

    // Bit 1 carries SCL, bit 0 carries SDA; pads idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            filt_q       <= 2'b11;
            filt_d1_q    <= 2'b11;
            flt_cnt_q[0] <= '0;
            flt_cnt_q[1] <= '0;
        end else begin
            sync1_q   <= {bus.scl_i, bus.sda_i};
            sync2_q   <= sync1_q;
            filt_d1_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= '0;
                end else if (flt_cnt_q[i] == 4'(FILTER_LEN - 1)) begin
                    filt_q[i]    <= sync2_q[i];
                    flt_cnt_q[i] <= '0;
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign scl_rise  = filt_q[1] & ~filt_d1_q[1];
    assign scl_fall  = ~filt_q[1] & filt_d1_q[1];
    assign start_det = filt_d1_q[0] & ~filt_q[0] & filt_q[1] & filt_d1_q[1];
    assign stop_det  = ~filt_d1_q[0] & filt_q[0] & filt_q[1] & filt_d1_q[1];
    assign rx_byte   = {shift_q, filt_q[0]};
    assign ptr_nxt   = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_is_rw = ({1'b0, ptr_q} < RW_LIM);

    for (genvar k = 0; k < NUM_TOT; k++) begin : g_regs
        if (k < NUM_RW) begin : g_rw
            assign all_regs[k]          = rw_q[k];
            assign rw_regs_o[8*k +: 8]  = rw_q[k];
        end else begin : g_ro
            assign all_regs[k] = ro_regs_i[8*(k-NUM_RW) +: 8];
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < NUM_TOT; k++)
            if (ptr_q == PTR_W'(k)) rd_byte = all_regs[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sda_oe_d  = sda_oe_q;
        bit_cnt_d = bit_cnt_q;
        ack_ph_d  = ack_ph_q;
        rd_mode_d = rd_mode_q;
        ld_tx     = 1'b0;
        tx_shift  = 1'b0;
        ptr_ld    = 1'b0;
        ptr_inc   = 1'b0;
        wr_en     = 1'b0;
        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d   = S_DEV_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            ack_ph_d  = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_PTR, S_WR_DATA: if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        ack_ph_d  = 1'b0;
                        if (state_q == S_DEV_ADDR) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d   = S_ADDR_ACK;
                                rd_mode_d = rx_byte[0];
                            end else begin
                                state_d = S_WAIT;
                            end
                        end else if (state_q == S_PTR) begin
                            if ({1'b0, rx_byte} < TOT_LIM) begin
                                state_d = S_PTR_ACK;
                                ptr_ld  = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end else begin
                            // Bytes aimed at RO indices are ACKed but dropped.
                            state_d = S_WR_ACK;
                            wr_en   = ptr_is_rw;
                            ptr_inc = 1'b1;
                        end
                    end
                end
                // First SCL fall starts the ACK pulse, the second ends it.
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_oe_d = 1'b1;
                        ack_ph_d = 1'b1;
                    end else begin
                        ack_ph_d = 1'b0;
                        sda_oe_d = 1'b0;
                        if (state_q != S_ADDR_ACK) begin
                            state_d = S_WR_DATA;
                        end else if (rd_mode_q) begin
                            state_d  = S_RD_DATA;
                            ld_tx    = 1'b1;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d = S_PTR;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_RD_ACK;
                        end else begin
                            tx_shift = 1'b1;
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (filt_q[0]) state_d  = S_WAIT;
                        else           ack_ph_d = 1'b1;
                    end else if (scl_fall && ack_ph_q) begin
                        ack_ph_d = 1'b0;
                        ld_tx    = 1'b1;
                        sda_oe_d = ~rd_byte[7];
                        state_d  = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            wr_idx_q  <= '0;
            wr_stb_q  <= 1'b0;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            ack_ph_q  <= 1'b0;
            rd_mode_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int k = 0; k < NUM_RW; k++) rw_q[k] <= RW_RESET;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            sda_oe_q  <= sda_oe_d;
            ack_ph_q  <= ack_ph_d;
            rd_mode_q <= rd_mode_d;
            wr_stb_q  <= wr_en;
            if (scl_rise) shift_q <= rx_byte[6:0];
            if (ld_tx)         tx_q <= rd_byte;
            else if (tx_shift) tx_q <= {tx_q[6:0], 1'b0};
            if (ptr_ld)                ptr_q <= rx_byte[PTR_W-1:0];
            else if (ptr_inc || ld_tx) ptr_q <= ptr_nxt;
            if (wr_en) wr_idx_q <= ptr_q;
            for (int k = 0; k < NUM_RW; k++)
                if (wr_en && ptr_q == PTR_W'(k)) rw_q[k] <= rx_byte;
            if (stop_det)       busy_q <= 1'b0;
            else if (start_det) busy_q <= 1'b1;
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign wr_stb_o   = wr_stb_q;
    assign wr_idx_o   = wr_idx_q;
    assign busy_o     = busy_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, transaction-level
// register model, strobe scoreboard and randomized traffic.
module tb_i2c_slave_regfile;
    localparam int Q = 12;  // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_slave_regfile_if bus();
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic [31:0] rw_regs;
    logic [31:0] ro_regs = {8'h78, 8'h56, 8'h34, 8'h12};
    logic        wr_stb;
    logic [2:0]  wr_idx;
    logic        busy;
    logic [3:0]  state;

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;
    assign sda_line  = bus.sda_i;

    i2c_slave_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rw_regs_o (rw_regs),
        .ro_regs_i (ro_regs),
        .wr_stb_o  (wr_stb),
        .wr_idx_o  (wr_idx),
        .busy_o    (busy),
        .state_o   (state)
    );

    int         total = 0;
    int         bad   = 0;
    int         oe_cnt = 0;
    int         mptr  = 0;
    logic [7:0] mdl_rw [4];
    logic [7:0] ro_vals [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] dbuf [4];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    always @(negedge clk) begin
        if (wr_stb) obs_q.push_back(8'(wr_idx));
        if (bus.sda_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] mdl_val(input int p);
        return (p < 4) ? mdl_rw[p] : ro_vals[p-4];
    endfunction

    function automatic logic [31:0] mdl_pack();
        return {mdl_rw[3], mdl_rw[2], mdl_rw[1], mdl_rw[0]};
    endfunction

    task automatic bus_start();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            if (glitch && i == 4) begin
                wq(2); scl_m = 1'b1; wq(1); scl_m = 1'b0; wq(Q - 3);
            end else begin
                wq(Q);
            end
            scl_m = 1'b1; wq(2*Q);
            scl_m = 1'b0; wq(Q);
        end
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        ack = sda_line; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wq(Q); scl_m = 1'b1;
            wq(Q); b[i] = sda_line;
            wq(Q); scl_m = 1'b0;
            wq(Q);
        end
        sda_m = nack; wq(Q);
        scl_m = 1'b1; wq(2*Q);
        scl_m = 1'b0; wq(Q);
        sda_m = 1'b1;
    endtask

    task automatic end_checks();
        int n;
        wq(Q);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("stb_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("stb_idx", 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
        check("rw_regs", rw_regs, mdl_pack());
    endtask

    // Write transaction: device byte, pointer byte, then n bytes from dbuf.
    task automatic m_write(input logic [6:0] dev, input logic [7:0] p, input int n,
                           input bit glitch, input bit stop);
        bit ack;
        bit ok;
        bus_start();
        check("busy_start", 32'(busy), 32'd1);
        write_byte({dev, 1'b0}, 1'b0, ack);
        ok = (dev == 7'h3C);
        check("addr_ack", 32'(ack), ok ? 32'd0 : 32'd1);
        write_byte(p, 1'b0, ack);
        ok = ok && (p < 8'd8);
        check("ptr_ack", 32'(ack), ok ? 32'd0 : 32'd1);
        if (ok) mptr = int'(p);
        for (int i = 0; i < n; i++) begin
            write_byte(dbuf[i], glitch && i == 0, ack);
            check("data_ack", 32'(ack), ok ? 32'd0 : 32'd1);
            if (ok) begin
                if (mptr < 4) begin
                    mdl_rw[mptr] = dbuf[i];
                    exp_q.push_back(8'(mptr));
                end
                mptr = (mptr + 1) % 8;
            end
        end
        if (stop) begin
            bus_stop();
            end_checks();
        end
    endtask

    task automatic m_read(input logic [6:0] dev, input int n);
        bit         ack;
        bit         ok;
        logic [7:0] b;
        bus_start();
        check("busy_start", 32'(busy), 32'd1);
        write_byte({dev, 1'b1}, 1'b0, ack);
        ok = (dev == 7'h3C);
        check("rd_addr_ack", 32'(ack), ok ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            check("rd_data", 32'(b), ok ? 32'(mdl_val(mptr)) : 32'hFF);
            if (ok) mptr = (mptr + 1) % 8;
        end
        bus_stop();
        end_checks();
    endtask

    initial begin
        bit ack;
        for (int i = 0; i < 4; i++) mdl_rw[i] = 8'h00;
        wq(5);
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_idx", 32'(wr_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_regs", rw_regs, 32'h0);
        rst = 1'b1;
        wq(5);

        dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
        m_write(7'h3C, 8'h01, 2, 1'b0, 1'b1);
        check("t1_reg1", 32'(rw_regs[15:8]), 32'hAA);
        check("t1_reg2", 32'(rw_regs[23:16]), 32'hBB);

        m_write(7'h3C, 8'h05, 0, 1'b0, 1'b0);
        m_read(7'h3C, 3);
        m_read(7'h3C, 1);

        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        m_write(7'h3C, 8'h03, 2, 1'b0, 1'b1);
        check("t3_reg3", 32'(rw_regs[31:24]), 32'h11);

        oe_cnt = 0;
        dbuf[0] = 8'h5A; dbuf[1] = 8'hC3;
        m_write(7'h3D, 8'h02, 2, 1'b0, 1'b1);
        check("nodev_oe_cycles", oe_cnt, 0);

        dbuf[0] = 8'hEE;
        m_write(7'h3C, 8'h08, 1, 1'b0, 1'b1);
        m_read(7'h3C, 1);

        dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
        m_write(7'h3C, 8'h00, 2, 1'b1, 1'b1);

        // Reset in the middle of a read while the slave drives a 0 bit.
        dbuf[0] = 8'h0F;
        m_write(7'h3C, 8'h00, 1, 1'b0, 1'b1);
        m_write(7'h3C, 8'h00, 0, 1'b0, 1'b1);
        bus_start();
        write_byte({7'h3C, 1'b1}, 1'b0, ack);
        check("mid_rd_ack", 32'(ack), 32'd0);
        check("mid_rd_drive", 32'(bus.sda_oe), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("async_rst_oe", 32'(bus.sda_oe), 32'd0);
        check("async_rst_regs", rw_regs, 32'h0);
        check("async_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) mdl_rw[i] = 8'h00;
        mptr = 0;
        scl_m = 1'b1; sda_m = 1'b1;
        wq(4);
        rst = 1'b1;
        wq(4);
        obs_q.delete();
        exp_q.delete();
        m_read(7'h3C, 1);

        for (int t = 0; t < 12; t++) begin
            int         kind;
            int         n;
            logic [6:0] dev;
            logic [7:0] p;
            kind = $urandom_range(0, 3);
            dev  = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127)) : 7'h3C;
            p    = 8'($urandom_range(0, 9));
            n    = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
            case (kind)
                0, 1: m_write(dev, p, n, 1'b0, 1'b1);
                2:    m_read(dev, n + 1);
                default: begin
                    m_write(7'h3C, p, n, 1'b0, 1'b0);
                    m_read(dev, $urandom_range(1, 3));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
Parametrised I2C slave register file, the next generation of the fixed 8-register i2cSlave. Device address, the RW/RO register split and the input glitch filter are generics. It adds a per-write strobe, pointer wrap, out-of-range pointer NACK and repeated-START support. It sits on the board-level SDA/SCL open-drain pads and exposes registers to local logic in the clk domain.

Parameters:
DEV_ADDR, 7'h3C, 7-bit I2C device address matched after START
NUM_RW, 4, number of read/write registers (1..128), indices 0..NUM_RW-1
NUM_RO, 4, number of read-only registers (0..128), indices NUM_RW..NUM_RW+NUM_RO-1
RW_RESET, 8'h00, reset value of every RW register
FILTER_LEN, 3, clk cycles an input must be stable before the filtered value changes (1..15)

Ports:
clk  input  1  system clock, at least 20x SCL rate
rst  input  1  asynchronous, active-low reset
scl_i  input  1  SCL pad input
sda_i  input  1  SDA pad input
sda_oe  output  1  1 = drive SDA low; 0 = release (open drain)
rw_regs_o  output  8*NUM_RW  RW register contents, reg k at bits [8k+7:8k]
ro_regs_i  input  8*max(NUM_RO,1)  RO register values, same packing
wr_stb_o  output  1  one-clk pulse per accepted RW data byte
wr_idx_o  output  PTR_W  index written, valid with wr_stb_o; PTR_W = clog2(NUM_RW+NUM_RO), minimum 1
busy_o  output  1  1 from START to STOP

Behaviour:
- Reset (rst=0, asynchronous): sda_oe=0, wr_stb_o=0, wr_idx_o=0, busy_o=0, rw_regs_o all RW_RESET, pointer=0, FSM=IDLE.
- Input path: 2-FF synchroniser on scl_i/sda_i, then a stability filter. The filtered output updates only after FILTER_LEN consecutive equal synchronised samples. Edges are detected on the filtered values.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high. Both are recognised in any state, including mid-byte. START (including repeated START) enters DEV_ADDR. STOP enters IDLE. Either one releases sda_oe the same clk.
- Bit timing: input bits are sampled on the filtered SCL rising edge. sda_oe changes only on the clk after a filtered SCL falling edge.
- FSM states: IDLE, DEV_ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
- DEV_ADDR collects 8 bits MSB first. If the upper 7 bits == DEV_ADDR: go to ADDR_ACK and drive ACK (sda_oe=1) for one SCL low-high-low period. Then R/W=0 goes to PTR; R/W=1 goes to RD_DATA with data loaded at the ACK SCL fall. Mismatch: go to WAIT with no ACK.
- PTR: 8 bits received. If the value < NUM_RW+NUM_RO, ACK and load the pointer, then go to WR_DATA. Otherwise NACK, leave the pointer unchanged, go to WAIT.
- WR_DATA: 8 bits received, then ACK (WR_ACK).
  - If pointer < NUM_RW: update the register, pulse wr_stb_o for exactly 1 clk with wr_idx_o=pointer, on the clk after the 8th SCL rise.
  - If the pointer is an RO index: ACK the byte, discard the data, no strobe.
  - Pointer then increments. It wraps from NUM_RW+NUM_RO-1 to 0.
- RD_DATA: shift out the pointed register MSB first. sda_oe = ~bit. RO values are captured at byte load time. Pointer increments with the same wrap on load.
- RD_ACK: sample the master bit on the SCL rise. 0 (ACK) goes to RD_DATA with the next byte. 1 (NACK) goes to WAIT with SDA released.
- WAIT: ignore bus traffic until START or STOP.
- A write to a register and a local read of rw_regs_o in the same clk: the old value is visible until the next clk.
- The pointer persists across transactions. Write-pointer-then-repeated-START-read reads from that pointer.
- rst asserted mid-transfer releases SDA immediately, because it is asynchronous.

Test Plan:
- Configuration for all scenarios: DEV_ADDR=7'h3C, NUM_RW=4, NUM_RO=4, ro_regs_i = {8'h78,8'h56,8'h34,8'h12}.
- Write 0x78, ptr 0x01, data 0xAA 0xBB, STOP -> ACK on all 4 bytes; reg1=AA, reg2=BB; two wr_stb_o pulses with idx 1 then 2; busy_o low after STOP.
- Write 0x78, ptr 0x05, repeated START, 0x79, read 3 bytes (ACK, ACK, NACK), STOP -> data 0x34, 0x56, 0x78; pointer=0 afterwards (wrap).
- Write 0x78, ptr 0x03, data 0x11 0x22, STOP -> reg3=11; 0x22 is ACKed to RO index 4 with no strobe and no change to ro; exactly one strobe.
- Address 0x7A (device 0x3D) followed by any bytes -> SDA never driven low; no strobes; registers unchanged.
- Pointer 0x08 -> NACK on the pointer byte; following data ignored; pointer keeps its previous value.
- 1-clk glitch on SCL during a data byte with FILTER_LEN=3 -> no extra bit sampled, byte received correctly. Separately, rst pulled low in the middle of a read -> sda_oe=0 asynchronously and registers return to 0x00.
